// File: rtl/des_key_sched_seq.sv
// rtl/des_key_sched_seq.sv - sequential DES round-key generator, K1..K16 or K16..K1 by handshake
module des_key_sched_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         decrypt,
    input  logic [64:1]  key,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [48:1]  round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Bit r set when the encrypt schedule shifts by two entering 1-based round r+1.
    localparam logic [15:0] SHIFT2 = 16'h7EFC;

    // DES numbers bits from 1 at the MSB, so DES bit n of a W-bit vector is [W+1-n].
    function automatic logic [56:1] pc1(input logic [64:1] k);
        logic [56:1] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[56 - i] = k[65 - PC1_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [48:1] pc2(input logic [56:1] cd);
        logic [48:1] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[48 - i] = cd[57 - PC2_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [28:1] rotl(input logic [28:1] x, input logic two);
        return two ? {x[26:1], x[28:27]} : {x[27:1], x[28]};
    endfunction

    function automatic logic [28:1] rotr(input logic [28:1] x, input logic two);
        return two ? {x[2:1], x[28:3]} : {x[1], x[28:2]};
    endfunction

    state_t      state_q, state_d;
    logic        dec_q, dec_d;
    logic [28:1] c_half_q, c_half_d;
    logic [28:1] d_half_q, d_half_d;
    logic [3:0]  idx_q, idx_d;
    logic        done_q, done_d;

    logic [56:1] key_pc1;
    logic [3:0]  idx_next;
    logic [3:0]  shift_sel;
    logic        shift_two;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            dec_q    <= 1'b0;
            c_half_q <= '0;
            d_half_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dec_q    <= dec_d;
            c_half_q <= c_half_d;
            d_half_q <= d_half_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dec_d     = dec_q;
        c_half_d  = c_half_q;
        d_half_d  = d_half_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        key_pc1   = pc1(key);
        idx_next  = idx_q + 4'd1;
        // Decrypt walks the shift table backwards: entering round n+1 uses entry 16-n (mod 16).
        shift_sel = dec_q ? (4'd0 - idx_next) : idx_next;
        shift_two = SHIFT2[shift_sel];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    dec_d   = decrypt;
                    idx_d   = '0;
                    if (decrypt) begin
                        c_half_d = key_pc1[56:29];
                        d_half_d = key_pc1[28:1];
                    end else begin
                        c_half_d = rotl(key_pc1[56:29], 1'b0);
                        d_half_d = rotl(key_pc1[28:1], 1'b0);
                    end
                end
            end
            S_RUN: begin
                if (key_ready) begin
                    if (idx_q == 4'd15) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_next;
                        if (dec_q) begin
                            c_half_d = rotr(c_half_q, shift_two);
                            d_half_d = rotr(d_half_q, shift_two);
                        end else begin
                            c_half_d = rotl(c_half_q, shift_two);
                            d_half_d = rotl(d_half_q, shift_two);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign key_valid = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign round_idx = idx_q;
    assign done      = done_q;
    assign round_key = key_valid ? pc2({c_half_q, d_half_q}) : '0;

endmodule

// File: tb/tb_des_key_sched_seq.sv
// tb/tb_des_key_sched_seq.sv - directed self-checking bench for des_key_sched_seq
module tb_des_key_sched_seq;

    logic         clk;
    logic         rst;
    logic         start;
    logic         decrypt;
    logic [64:1]  key;
    logic         key_ready;
    logic         key_valid;
    logic [48:1]  round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    localparam logic [64:1] FIPS_KEY = 64'h133457799BBCDFF1;

    // Subkeys K1..K16 for the FIPS worked-example key.
    localparam logic [47:0] ENC_KEYS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_sched_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .decrypt   (decrypt),
        .key       (key),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] exp_key(input bit dec, input int n);
        return dec ? ENC_KEYS[15 - n] : ENC_KEYS[n];
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 64'(key_valid), 64'd0);
        check({tag, "_busy"},  64'(busy),      64'd0);
        check({tag, "_key"},   64'(round_key), 64'd0);
    endtask

    // Issue start on the next edge; returns at the negedge after that edge.
    task automatic start_sched(input bit dec, input logic [64:1] k);
        @(negedge clk);
        start   = 1'b1;
        decrypt = dec;
        key     = k;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // mode 0: always ready; 1: 3-cycle stall at idx 4 plus random stalls;
    // 2: always ready, with start pulse and key/decrypt changes mid-run.
    task automatic consume(input bit dec, input int mode, input int lim, output int cycles);
        int n     = 0;
        int cyc   = 0;
        int stall = 0;
        while (n < lim && cyc < 200) begin
            check($sformatf("d%0d_m%0d_valid_%0d", dec, mode, n), 64'(key_valid), 64'd1);
            check($sformatf("d%0d_m%0d_idx_%0d",   dec, mode, n), 64'(round_idx), 64'(n));
            check($sformatf("d%0d_m%0d_key_%0d",   dec, mode, n), 64'(round_key), 64'(exp_key(dec, n)));
            key_ready = 1'b1;
            start     = 1'b0;
            if (mode == 1) begin
                if (n == 4 && stall < 3) begin
                    key_ready = 1'b0;
                    stall++;
                end else if (n != 4) begin
                    key_ready = ($urandom_range(0, 3) != 0);
                end
            end else if (mode == 2 && n == 5) begin
                start   = 1'b1;
                key     = 64'hFFFFFFFFFFFFFFFF;
                decrypt = ~dec;
            end
            if (key_ready) n++;
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        key_ready = 1'b1;
        check($sformatf("d%0d_m%0d_bound", dec, mode), 64'(n), 64'(lim));
        cycles = cyc;
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        start     = 1'b0;
        decrypt   = 1'b0;
        key       = '0;
        key_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_idx",  64'(round_idx), 64'd0);
        check("reset_done", 64'(done),      64'd0);
        rst = 1'b0;

        // Encrypt with FIPS key
        start_sched(1'b0, FIPS_KEY);
        consume(1'b0, 0, 16, cyc);
        check("enc_latency", 64'(cyc), 64'd16);
        check("enc_done",    64'(done), 64'd1);
        check_idle("enc_end");
        @(negedge clk);
        check("enc_done_pulse", 64'(done), 64'd0);

        // Decrypt with the same key
        start_sched(1'b1, FIPS_KEY);
        consume(1'b1, 0, 16, cyc);
        check("dec_done", 64'(done), 64'd1);
        check_idle("dec_end");

        // Backpressure
        start_sched(1'b0, FIPS_KEY);
        consume(1'b0, 1, 16, cyc);
        check("bp_done", 64'(done), 64'd1);

        // Ignored inputs during RUN
        start_sched(1'b0, FIPS_KEY);
        consume(1'b0, 2, 16, cyc);
        check("ign_done", 64'(done), 64'd1);
        @(negedge clk);
        check_idle("ign_after");

        // Back-to-back: start in done cycle
        start_sched(1'b0, FIPS_KEY);
        consume(1'b0, 0, 16, cyc);
        check("b2b_done", 64'(done), 64'd1);
        start   = 1'b1;
        decrypt = 1'b1;
        key     = FIPS_KEY;
        @(negedge clk);
        start = 1'b0;
        consume(1'b1, 0, 16, cyc);
        check("b2b_dec_done", 64'(done), 64'd1);

        // Asynchronous reset mid-run at idx 7
        start_sched(1'b0, FIPS_KEY);
        consume(1'b0, 0, 7, cyc);
        check("mid_idx", 64'(round_idx), 64'd7);
        #2 rst = 1'b1;
        #1;
        check_idle("async_rst");
        check("async_rst_idx",  64'(round_idx), 64'd0);
        check("async_rst_done", 64'(done),      64'd0);
        @(negedge clk);
        check_idle("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_rst");
        start_sched(1'b0, FIPS_KEY);
        consume(1'b0, 0, 16, cyc);
        check("post_rst_done", 64'(done), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
